// File: rtl/stream_dwc_pkg.sv
// Shared types and elaboration helpers for the AXI-Stream lane-count converter.
package stream_dwc_pkg;

  typedef enum logic [1:0] {PASS, UP, DOWN} dwc_mode_e;
  typedef enum logic {EMPTY, HOLD} dwn_state_e;

  function automatic int pad8(input int bits);
    return ((bits + 7) / 8) * 8;
  endfunction

  function automatic dwc_mode_e dwc_mode(input int in_pe, input int out_pe);
    if (in_pe == out_pe) return PASS;
    if (out_pe > in_pe) return UP;
    return DOWN;
  endfunction

endpackage

// File: rtl/stream_lane_dwc.sv
// Reshapes IN_PE elements per beat into OUT_PE elements per beat, preserving order.
//
// DOWN-mode state | meaning
// EMPTY           | no word held, output_tvalid low, ready for a new input word
// HOLD            | word held, slice sel_q presented on the output
module stream_lane_dwc
  import stream_dwc_pkg::*;
#(
  parameter int ELEM_WIDTH = 8,
  parameter int IN_PE = 1,
  parameter int OUT_PE = 1,
  localparam int IW = pad8(IN_PE * ELEM_WIDTH),
  localparam int OW = pad8(OUT_PE * ELEM_WIDTH)
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  input  logic          input_tvalid,
  output logic          input_tready,
  input  logic [IW-1:0] input_tdata,
  output logic          output_tvalid,
  input  logic          output_tready,
  output logic [OW-1:0] output_tdata
);

  localparam int IN_EW = IN_PE * ELEM_WIDTH;
  localparam int OUT_EW = OUT_PE * ELEM_WIDTH;
  localparam dwc_mode_e MODE = dwc_mode(IN_PE, OUT_PE);

  if (ELEM_WIDTH < 1 || IN_PE < 1 || OUT_PE < 1) begin : g_bad_size
    $error("stream_lane_dwc: ELEM_WIDTH, IN_PE and OUT_PE must be >= 1");
  end
  if (((IN_PE > OUT_PE) ? (IN_PE % OUT_PE) : (OUT_PE % IN_PE)) != 0) begin : g_bad_ratio
    $error("stream_lane_dwc: larger PE count must be a multiple of the smaller");
  end

  // Input padding bits carry no data; fold them into a sink so they count as consumed.
  logic unused_pad;
  assign unused_pad = ^input_tdata;

  logic [IN_EW-1:0] in_elems;
  assign in_elems = input_tdata[IN_EW-1:0];

  if (MODE == PASS) begin : g_pass
    logic [OUT_EW-1:0] obuf_q;
    logic              vld_q;
    logic              in_hs;

    assign input_tready  = ap_rst_n && (!vld_q || output_tready);
    assign in_hs         = input_tvalid && input_tready;
    assign output_tvalid = vld_q;
    assign output_tdata  = OW'(obuf_q);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        obuf_q <= '0;
        vld_q  <= 1'b0;
      end else if (in_hs) begin
        obuf_q <= in_elems;
        vld_q  <= 1'b1;
      end else if (output_tready) begin
        vld_q <= 1'b0;
      end
    end

  end else if (MODE == UP) begin : g_up
    localparam int R = OUT_PE / IN_PE;
    localparam int CW = $clog2(R);

    logic [CW-1:0]         cnt_q;
    logic [(R-1)*IN_EW-1:0] asm_q;
    logic [OUT_EW-1:0]     obuf_q;
    logic                  vld_q;
    logic                  last_slot;
    logic                  in_hs;

    assign last_slot     = (cnt_q == CW'(R - 1));
    // Only the completing beat needs obuf free; lower slots keep filling during a stall.
    assign input_tready  = ap_rst_n && !(last_slot && vld_q && !output_tready);
    assign in_hs         = input_tvalid && input_tready;
    assign output_tvalid = vld_q;
    assign output_tdata  = OW'(obuf_q);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        cnt_q  <= '0;
        asm_q  <= '0;
        obuf_q <= '0;
        vld_q  <= 1'b0;
      end else if (in_hs && last_slot) begin
        obuf_q <= {in_elems, asm_q};
        vld_q  <= 1'b1;
        cnt_q  <= '0;
      end else begin
        if (output_tready) vld_q <= 1'b0;
        if (in_hs) begin
          for (int k = 0; k < R - 1; k++) begin
            if (cnt_q == CW'(k)) asm_q[k*IN_EW +: IN_EW] <= in_elems;
          end
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end

  end else begin : g_down
    localparam int R = IN_PE / OUT_PE;
    localparam int CW = $clog2(R);

    dwn_state_e        state_q;
    logic [CW-1:0]     sel_q;
    logic [IN_EW-1:0]  hold_q;
    logic [OUT_EW-1:0] slice;
    logic              last_sel;
    logic              in_hs;

    assign last_sel      = (sel_q == CW'(R - 1));
    assign input_tready  = ap_rst_n && ((state_q == EMPTY) || (last_sel && output_tready));
    assign in_hs         = input_tvalid && input_tready;
    assign output_tvalid = (state_q == HOLD);
    assign output_tdata  = OW'(slice);

    always_comb begin
      slice = '0;
      for (int k = 0; k < R; k++) begin
        if (sel_q == CW'(k)) slice = hold_q[k*OUT_EW +: OUT_EW];
      end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        state_q <= EMPTY;
        sel_q   <= '0;
        hold_q  <= '0;
      end else begin
        case (state_q)
          EMPTY: begin
            if (in_hs) begin
              hold_q  <= in_elems;
              sel_q   <= '0;
              state_q <= HOLD;
            end
          end
          HOLD: begin
            if (output_tready) begin
              if (!last_sel) begin
                sel_q <= sel_q + CW'(1);
              end else if (in_hs) begin
                hold_q <= in_elems;
                sel_q  <= '0;
              end else begin
                state_q <= EMPTY;
              end
            end
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

endmodule
